// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/capture stage.
package div_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;
  localparam logic [15:0] DZ_QUO  = 16'hFFFF;
  localparam logic [15:0] MIN_NEG = 16'h8000;
endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand abs and result sign correction.
module div_sign_fix (
  input  logic [15:0] din,
  input  logic        neg,
  output logic [15:0] dout
);
  assign dout = neg ? (~din + 16'd1) : din;
endmodule

// File: rtl/div_issue.sv
// Issues one divide job into the free-running sequential divider and holds the
// sign-corrected result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | operands held, waiting for a divider sample slot
// RUN   | job launched, waiting for the divider to finish
// DONE  | result held until res_ready
module div_issue
  import div_pkg::*;
(
  input  logic        CK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_signed,
  output logic [15:0] dv_a,
  output logic [15:0] dv_b,
  input  logic        dv_busy,
  input  logic [15:0] dv_quo,
  input  logic [15:0] dv_rem,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_quo,
  output logic [15:0] res_rem,
  output logic        res_dz,
  output logic        res_ovf
);
  state_t      state;
  logic        accept;
  logic [15:0] abs_a, abs_b, fix_quo, fix_rem;
  logic        sign_q, sign_r, ovf_q;

  assign accept = req_valid & req_ready;

  div_sign_fix u_abs_a   (.din(req_a),  .neg(req_signed & req_a[15]), .dout(abs_a));
  div_sign_fix u_abs_b   (.din(req_b),  .neg(req_signed & req_b[15]), .dout(abs_b));
  div_sign_fix u_fix_quo (.din(dv_quo), .neg(sign_q),                 .dout(fix_quo));
  div_sign_fix u_fix_rem (.din(dv_rem), .neg(sign_r),                 .dout(fix_rem));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res_quo   <= '0;
      res_rem   <= '0;
      res_dz    <= 1'b0;
      res_ovf   <= 1'b0;
      dv_a      <= '0;
      dv_b      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_b == '0) begin
              // divide by zero never reaches the divider
              res_valid <= 1'b1;
              res_dz    <= 1'b1;
              res_ovf   <= 1'b0;
              res_quo   <= DZ_QUO;
              res_rem   <= req_a;
              state     <= DONE;
            end else begin
              dv_a   <= abs_a;
              dv_b   <= abs_b;
              sign_q <= req_signed & (req_a[15] ^ req_b[15]);
              sign_r <= req_signed & req_a[15];
              ovf_q  <= req_signed && (req_a == MIN_NEG) && (req_b == 16'hFFFF);
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!dv_busy) state <= RUN;
        end
        RUN: begin
          // first idle edge after our own launch carries our result
          if (!dv_busy) begin
            res_quo   <= fix_quo;
            res_rem   <= fix_rem;
            res_dz    <= 1'b0;
            res_ovf   <= ovf_q;
            res_valid <= 1'b1;
            dv_a      <= '0;
            dv_b      <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: free-running divider model, vector table and scoreboard.
module tb_div_issue;
  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_signed = 1'b0;
  logic [15:0] dv_a, dv_b;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_quo, res_rem;
  logic        res_dz, res_ovf;

  // divider model: no reset, samples on every idle edge, busy for 17 edges
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_a = '0, m_b = '0, m_quo = '0, m_rem = '0;

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (!m_busy) begin
      m_a <= dv_a; m_b <= dv_b; m_cnt <= 16; m_busy <= 1'b1;
    end else if (m_cnt == 0) begin
      m_busy <= 1'b0;
      m_quo  <= (m_b == 16'd0) ? 16'hFFFF : m_a / m_b;
      m_rem  <= (m_b == 16'd0) ? m_a : m_a % m_b;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  div_issue dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .dv_a(dv_a), .dv_b(dv_b), .dv_busy(m_busy), .dv_quo(m_quo), .dv_rem(m_rem),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quo(res_quo), .res_rem(res_rem), .res_dz(res_dz), .res_ovf(res_ovf)
  );

  typedef struct packed {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] ma, mb, quo, rem;
    logic        dz, ovf;
  } vec_t;

  typedef struct {
    logic [15:0] quo, rem;
    logic        dz, ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // align: -1 = accept on an edge where busy is low, k>=0 = busy with k counts left
  task automatic issue_req(input vec_t v, input int align, input int lat);
    int   k = 0;
    bit   ok = 0;
    exp_t e;
    while (!ok && k < 100) begin
      @(negedge CK);
      ok = (align < 0) ? !m_busy : (m_busy && m_cnt == align);
      k++;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL align: got timeout expected slot %0d", align);
    end
    req_a = v.a; req_b = v.b; req_signed = v.s; req_valid = 1'b1; res_ready = 1'b0;
    @(posedge CK); #1;
    req_valid = 1'b0;
    e.quo = v.quo; e.rem = v.rem; e.dz = v.dz; e.ovf = v.ovf; e.lat = lat;
    sb.push_back(e);
    check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    if (!v.dz) begin
      check("dv_a", {16'd0, dv_a}, {16'd0, v.ma});
      check("dv_b", {16'd0, dv_b}, {16'd0, v.mb});
    end
  endtask

  task automatic collect_res(input int hold);
    int   n = 0;
    exp_t e;
    while (!res_valid && n < 200) begin
      @(posedge CK); #1;
      n++;
    end
    check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: got result expected none");
    end else begin
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("res_quo", {16'd0, res_quo}, {16'd0, e.quo});
      check("res_rem", {16'd0, res_rem}, {16'd0, e.rem});
      check("res_dz",  {31'd0, res_dz},  {31'd0, e.dz});
      check("res_ovf", {31'd0, res_ovf}, {31'd0, e.ovf});
      for (int i = 0; i < hold; i++) begin
        @(posedge CK); #1;
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_quo",   {16'd0, res_quo},   {16'd0, e.quo});
        check("hold_rem",   {16'd0, res_rem},   {16'd0, e.rem});
        check("hold_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    res_ready = 1'b1;
    @(posedge CK); #1;
    res_ready = 1'b0;
    check("retire_valid", {31'd0, res_valid}, 32'd0);
    check("retire_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    //            a         b         s     ma        mb        quo       rem       dz    ovf
    tbl[0]  = '{16'd1000, 16'd7,    1'b0, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 1'b0};
    tbl[1]  = '{16'hFFF9, 16'd2,    1'b1, 16'd7,    16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
    tbl[2]  = '{16'h1234, 16'd0,    1'b0, 16'd0,    16'd0,    16'hFFFF, 16'h1234, 1'b1, 1'b0};
    tbl[3]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0, 1'b1};
    tbl[4]  = '{16'hFFFF, 16'd3,    1'b0, 16'hFFFF, 16'd3,    16'h5555, 16'd0,    1'b0, 1'b0};
    tbl[5]  = '{16'hFFFF, 16'd3,    1'b1, 16'd1,    16'd3,    16'd0,    16'hFFFF, 1'b0, 1'b0};
    tbl[6]  = '{16'd7,    16'hFFFE, 1'b1, 16'd7,    16'd2,    16'hFFFD, 16'd1,    1'b0, 1'b0};
    tbl[7]  = '{16'hFFF9, 16'hFFFE, 1'b1, 16'd7,    16'd2,    16'd3,    16'hFFFF, 1'b0, 1'b0};
    tbl[8]  = '{16'h8000, 16'd2,    1'b1, 16'h8000, 16'd2,    16'hC000, 16'd0,    1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'd0,    1'b1, 16'd0,    16'd0,    16'hFFFF, 16'h8000, 1'b1, 1'b0};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0};
    tbl[11] = '{16'hABCD, 16'd1,    1'b0, 16'hABCD, 16'd1,    16'hABCD, 16'd0,    1'b0, 1'b0};

    repeat (3) @(negedge CK);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_quo",   {16'd0, res_quo},   32'd0);
    check("rst_res_rem",   {16'd0, res_rem},   32'd0);
    check("rst_res_dz",    {31'd0, res_dz},    32'd0);
    check("rst_res_ovf",   {31'd0, res_ovf},   32'd0);
    check("rst_dv_a",      {16'd0, dv_a},      32'd0);
    check("rst_dv_b",      {16'd0, dv_b},      32'd0);
    RST = 1'b0;

    // best-case slot: accept on the edge where the divider drops busy
    for (int i = 0; i < 12; i++) begin
      issue_req(tbl[i], 0, tbl[i].dz ? 0 : 19);
      collect_res(0);
    end

    // busy low at the accept edge is not a launch
    issue_req(tbl[0], -1, 36);
    collect_res(0);

    // divider mid-run at accept, consumer stalls for 5 cycles
    issue_req('{16'd3001, 16'hFFFB, 1'b1, 16'd3001, 16'd5, 16'hFDA8, 16'd1, 1'b0, 1'b0}, 10, 29);
    collect_res(5);

    // reset in RUN drops the job; the stale divider result must not surface
    issue_req('{16'd5000, 16'd3, 1'b0, 16'd5000, 16'd3, 16'd1666, 16'd2, 1'b0, 1'b0}, 0, 19);
    repeat (8) @(posedge CK);
    #1 RST = 1'b1;
    #1;
    sb.delete();
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_dv_a",      {16'd0, dv_a},      32'd0);
    @(negedge CK);
    RST = 1'b0;
    issue_req('{16'd100, 16'd10, 1'b0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b0}, 0, 19);
    collect_res(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div_issue.md
# div_issue

Operand issue and result capture stage placed directly in front of the ALU's 16-bit sequential divider. Accepts one divide request at a time over a valid/ready handshake and converts signed operands to magnitudes. Launches the request into the free-running divider on a legal slot, captures its quotient and remainder, applies sign correction, and holds the result until the consumer takes it. Divide-by-zero is resolved locally without launching.

## Interface
- No parameters; data width fixed at 16.
- `CK  in  1` — single clock, rising edge.
- `RST  in  1` — asynchronous, active-high reset.
- `req_valid  in  1` — request offered.
- `req_ready  out  1` — request accepted when high together with req_valid at a CK edge.
- `req_a  in  16` — dividend.
- `req_b  in  16` — divisor.
- `req_signed  in  1` — 1 = two's-complement operands, 0 = unsigned.
- `dv_a  out  16` — dividend magnitude to the divider.
- `dv_b  out  16` — divisor magnitude to the divider.
- `dv_busy  in  1` — divider busy.
- `dv_quo  in  16` — divider quotient.
- `dv_rem  in  16` — divider remainder.
- `res_valid  out  1` — result held.
- `res_ready  in  1` — consumer takes the result when high together with res_valid.
- `res_quo  out  16` — final quotient.
- `res_rem  out  16` — final remainder.
- `res_dz  out  1` — divide by zero.
- `res_ovf  out  1` — signed overflow (-32768 / -1).

## Operation
- Divider contract, fixed:
  - On every CK edge where dv_busy is low, the divider samples dv_a/dv_b and raises busy.
  - It drops busy 17 edges later.
  - While busy is low, dv_quo/dv_rem hold the result of the previous sample.
  - The divider has no reset and free-runs; this block decides which samples are real jobs.
- FSM states:
  - IDLE: req_ready=1. On accept:
    - b==0: go DONE with res_dz=1, res_quo=16'hFFFF, res_rem=req_a (raw), res_ovf=0.
    - otherwise: register magnitudes |a|, |b| (abs only when req_signed), sign_q=a[15]^b[15], sign_r=a[15] (both 0 when unsigned); go WAIT.
  - WAIT: edge with dv_busy==0 is the launch edge; go RUN.
  - RUN: next edge with dv_busy==0 captures dv_quo/dv_rem and goes to DONE.
  - DONE: res_valid=1, outputs stable; on res_ready go IDLE.
- Sign fix:
  - res_quo = sign_q ? -dv_quo : dv_quo.
  - res_rem = sign_r ? -dv_rem : dv_rem.
  - Arithmetic is modulo 2^16.
- Magnitude of 16'h8000 signed is 16'h8000 (fits unsigned).
- res_ovf=1 only for signed a=16'h8000, b=16'hFFFF; res_quo=16'h8000, res_rem=0.
- dv_a/dv_b are driven from the held magnitudes in WAIT and RUN, and 0 in IDLE/DONE.
- req_ready is low in WAIT, RUN and DONE; exactly one job is outstanding.

## Timing
- Reset values: req_ready=1 (state IDLE), res_valid=0, res_quo=0, res_rem=0, res_dz=0, res_ovf=0, dv_a=0, dv_b=0.
- Launch edge L is the first edge after accept with dv_busy low: 1 to 18 edges after accept.
- Capture occurs at edge L+18; res_valid is high from L+18.
- Best-case accept-to-res_valid is 19 edges.
- Divide-by-zero: res_valid is high the edge after accept.
- res_valid falls at the edge where res_ready is seen; next accept is possible one edge later (IDLE).
- res_ready held high in DONE retires in one cycle; no combinational path from res_ready to req_ready.
- RST mid-WAIT/RUN/DONE: immediately IDLE, job dropped. The divider's in-flight computation is ignored because only RUN captures, and only after its own launch.
- dv_busy low while entering WAIT from IDLE in the same edge is not a launch; launch needs state WAIT at the edge.

## Structure
- Package `div_pkg`:
  - state enum {IDLE, WAIT, RUN, DONE};
  - DZ_QUO = 16'hFFFF;
  - MIN_NEG = 16'h8000.
- Sub-module `div_sign_fix`: combinational conditional two's-complement negate (16-bit in, negate flag, 16-bit out).
  - Instantiated four times: two abs conversions, two result corrections.

## Test plan
- Unsigned 1000/7, dv_busy model idle -> res_quo=142, res_rem=6, res_valid exactly 19 edges after accept.
- Signed -7/2 (16'hFFF9, 2) -> dv_a=7, dv_b=2; res_quo=16'hFFFD, res_rem=16'hFFFF.
- Divisor 0 with a=16'h1234 -> res_valid next edge; res_dz=1, res_quo=16'hFFFF, res_rem=16'h1234; dv_busy samples never counted as launch.
- Signed 16'h8000/16'hFFFF -> res_ovf=1, res_quo=16'h8000, res_rem=0.
- Accept while model divider is mid-run (busy high 10 more edges) -> launch waits for busy-low edge; result correct; res_ready held low 5 cycles keeps outputs stable and req_ready low.
- Assert RST in RUN, then issue 100/10 -> res_quo=10, res_rem=0; stale divider result never appears on res_*.
